// File: rtl/full_adder_pkg.sv
// Shared constants and golden-sum helper for the registered ripple-carry adder.
// Used by full_adder, its interface and verification code.
package full_adder_pkg;

  localparam int FA_MAX_WIDTH = 64;

  // Exact (FA_MAX_WIDTH+1)-bit sum; callers zero-extend narrower operands and keep [WIDTH:0].
  function automatic logic [FA_MAX_WIDTH:0] fa_ref(input logic [FA_MAX_WIDTH-1:0] a,
                                                   input logic [FA_MAX_WIDTH-1:0] b,
                                                   input logic                    cin);
    return {1'b0, a} + {1'b0, b} + {{FA_MAX_WIDTH{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder. The ovf signal exists only when
// FULL_ADDER_OVF_EN is defined.
interface full_adder_if #(
  parameter int WIDTH = 4
);
  import full_adder_pkg::*;

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef FULL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin,
    input  out_valid, sum, cout
`ifdef FULL_ADDER_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, cin,
    output out_valid, sum, cout
`ifdef FULL_ADDER_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/full_adder_cell.sv
// One-bit combinational full-adder cell: sum and majority carry.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder built from fa_cell instances.
// Define FULL_ADDER_OVF_EN to add the registered signed-overflow output.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  full_adder_if.slave  bus
);

  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
    $error("full_adder: WIDTH %0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
  end

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = bus.cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    fa_cell u_cell (
      .a  (bus.a[gi]),
      .b  (bus.b[gi]),
      .ci (c[gi]),
      .s  (s[gi]),
      .co (c[gi+1])
    );
  end

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             valid_q, valid_d;

  // Loads are gated by in_valid so idle-cycle X/Z on the operands never reaches the registers.
  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = bus.in_valid;
    if (bus.in_valid) begin
      sum_d  = s;
      cout_d = c[WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = valid_q;

`ifdef FULL_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_comb begin
    ovf_d = ovf_q;
    if (bus.in_valid) begin
      ovf_d = c[WIDTH] ^ c[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: a WIDTH=4 and a WIDTH=1 instance checked
// every cycle against an arithmetic model, plus directed literal expectations.
module tb_full_adder;
  import full_adder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  full_adder_if #(.WIDTH(4)) if4 ();
  full_adder_if #(.WIDTH(1)) if1 ();

  full_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  full_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  typedef struct packed {
    logic [63:0] s;
    logic        co;
    logic        ov;
  } res_t;

  // Unsigned result from integer addition; overflow from the signed interpretation's range.
  function automatic res_t model_add(input int w, input logic [63:0] a,
                                     input logic [63:0] b, input logic cin);
    res_t r;
    longint unsigned m    = (64'd1 << w) - 64'd1;
    longint unsigned t    = (a & m) + (b & m) + 64'(cin);
    longint          half = longint'(64'd1 << (w - 1));
    longint          sa   = longint'(a & m);
    longint          sb   = longint'(b & m);
    longint          st;
    if (sa >= half) sa = sa - 2 * half;
    if (sb >= half) sb = sb - 2 * half;
    st   = sa + sb + longint'(cin);
    r.s  = t & m;
    r.co = t[w];
    r.ov = (st >= half) || (st < -half);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  res_t e4, e1;
  logic v4, v1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e4 <= '0;
      e1 <= '0;
      v4 <= 1'b0;
      v1 <= 1'b0;
    end else begin
      v4 <= if4.in_valid;
      v1 <= if1.in_valid;
      if (if4.in_valid) e4 <= model_add(4, 64'(if4.a), 64'(if4.b), if4.cin);
      if (if1.in_valid) e1 <= model_add(1, 64'(if1.a), 64'(if1.b), if1.cin);
    end
  end

  // Outputs are defined on every cycle (hold semantics), so compare continuously.
  always @(negedge clk) begin
    check("cmp_v4",    64'(if4.out_valid), 64'(v4));
    check("cmp_sum4",  64'(if4.sum),       64'(e4.s[3:0]));
    check("cmp_cout4", 64'(if4.cout),      64'(e4.co));
    check("cmp_v1",    64'(if1.out_valid), 64'(v1));
    check("cmp_sum1",  64'(if1.sum),       64'(e1.s[0]));
    check("cmp_cout1", 64'(if1.cout),      64'(e1.co));
`ifdef FULL_ADDER_OVF_EN
    check("cmp_ovf4",  64'(if4.ovf),       64'(e4.ov));
    check("cmp_ovf1",  64'(if1.ovf),       64'(e1.ov));
`endif
  end

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic v);
    @(negedge clk);
    if4.a        = a;
    if4.b        = b;
    if4.cin      = cin;
    if4.in_valid = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]           last_sum;
    logic                 last_cout;
    logic [FA_MAX_WIDTH:0] golden;
    logic [2:0]           combo;

    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("reset_sum",   64'(if4.sum),       64'd0);
    check("reset_cout",  64'(if4.cout),      64'd0);
    check("reset_valid", 64'(if4.out_valid), 64'd0);
`ifdef FULL_ADDER_OVF_EN
    check("reset_ovf",   64'(if4.ovf),       64'd0);
`endif
    rst = 1'b0;

    drive4(4'b0010, 4'b0111, 1'b0, 1'b1);
    @(posedge clk); #1;
    $display("txn w4 a=2 b=7 cin=0 sum=%0h cout=%0b", if4.sum, if4.cout);
    check("d1_sum",   64'(if4.sum),       64'h9);
    check("d1_cout",  64'(if4.cout),      64'd0);
    check("d1_valid", 64'(if4.out_valid), 64'd1);
    check("d1_model", 64'(e4.s),          64'h9);
`ifdef FULL_ADDER_OVF_EN
    check("d1_ovf",   64'(if4.ovf),       64'd1);
`endif

    drive4(4'hF, 4'h1, 1'b0, 1'b1);
    @(posedge clk); #1;
    $display("txn w4 a=f b=1 cin=0 sum=%0h cout=%0b", if4.sum, if4.cout);
    check("d2_sum",  64'(if4.sum),  64'h0);
    check("d2_cout", 64'(if4.cout), 64'd1);
    check("d2_model_cout", 64'(e4.co), 64'd1);

    drive4(4'hF, 4'hF, 1'b1, 1'b1);
    @(posedge clk); #1;
    $display("txn w4 a=f b=f cin=1 sum=%0h cout=%0b", if4.sum, if4.cout);
    check("d3_sum",  64'(if4.sum),  64'hF);
    check("d3_cout", 64'(if4.cout), 64'd1);

    // Reset mid-cycle with a valid operand pending: clears at once and swallows that edge.
    drive4(4'h3, 4'h4, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_sum",   64'(if4.sum),       64'd0);
    check("rst_async_cout",  64'(if4.cout),      64'd0);
    check("rst_async_valid", 64'(if4.out_valid), 64'd0);
    @(posedge clk); #1;
    check("rst_edge_valid",  64'(if4.out_valid), 64'd0);
    check("rst_edge_sum",    64'(if4.sum),       64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    $display("txn w4 a=3 b=4 cin=0 after reset sum=%0h", if4.sum);
    check("post_rst_sum",   64'(if4.sum),       64'h7);
    check("post_rst_valid", 64'(if4.out_valid), 64'd1);

    // WIDTH=1 exhaustive: {cout,sum} is the population count of the three inputs.
    drive4(4'h0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      combo = 3'(i);
      @(negedge clk);
      if1.a        = combo[2];
      if1.b        = combo[1];
      if1.cin      = combo[0];
      if1.in_valid = 1'b1;
      @(posedge clk); #1;
      $display("txn w1 a=%0b b=%0b cin=%0b cout=%0b sum=%0b", combo[2], combo[1], combo[0],
               if1.cout, if1.sum);
      check("w1_exh", 64'({if1.cout, if1.sum}), 64'($countones(combo)));
    end
    @(negedge clk);
    if1.in_valid = 1'b0;

    // 20 back-to-back random operands, then idle cycles with scrambled operands.
    for (int i = 0; i < 20; i++) begin
      drive4(4'($urandom), 4'($urandom), 1'($urandom), 1'b1);
      golden = fa_ref(FA_MAX_WIDTH'(if4.a), FA_MAX_WIDTH'(if4.b), if4.cin);
      @(posedge clk); #1;
      $display("txn w4 rnd a=%0h b=%0h cin=%0b sum=%0h cout=%0b", if4.a, if4.b, if4.cin,
               if4.sum, if4.cout);
      check("rnd_fa_ref", 64'({e4.co, e4.s[3:0]}), 64'(golden[4:0]));
      check("rnd_valid",  64'(if4.out_valid),     64'd1);
    end
    last_sum  = e4.s[3:0];
    last_cout = e4.co;
    for (int i = 0; i < 3; i++) begin
      drive4(4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
      @(posedge clk); #1;
      $display("txn w4 idle sum=%0h cout=%0b valid=%0b", if4.sum, if4.cout, if4.out_valid);
      check("idle_sum",   64'(if4.sum),       64'(last_sum));
      check("idle_cout",  64'(if4.cout),      64'(last_cout));
      check("idle_valid", 64'(if4.out_valid), 64'd0);
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
